seg_scan_driver: RTL and testbench

Time-multiplexed 7-segment scan driver for the 4-digit time display.
- Upstream: drives the 2-bit select into the 4:1 digit Selector.
- Downstream: consumes the Selector's 4-bit digit result, decodes it to segments and drives the anode enables.
- Each digit slot has a blanking gap so segment data settles before its anode turns on (no ghosting).

---
 rtl/seg_scan_driver_pkg.sv | 21 ++
 rtl/seg_scan_driver_hex7seg.sv | 12 +
 rtl/seg_scan_driver.sv | 103 ++++++++++
 tb/tb_seg_scan_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_st_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Index 0 is the rightmost entry
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
// Covers 0-9 and A-F.
module hex7seg
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPH[digit];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with per-slot blanking.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int PWM_DUTY     = 0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit_res,
   input  logic [3:0] dp_mask,
   input  logic [3:0] blank_mask,
   output logic [1:0] sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV <= BLANK_CYCLES || BLANK_CYCLES < 2 || PWM_DUTY < 0)
   begin : g_bad_cfg
      $error("seg_scan_driver: invalid parameters");
   end

   logic [CW-1:0] cnt;
   scan_st_t      state;
   logic          last;
   logic          blank_end;
   logic [6:0]    glyph;
   logic          lz;

   assign last      = (cnt == CW'(CLK_DIV - 1));
   assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));

   hex7seg u_dec (
      .digit (digit_res),
      .seg   (glyph)
   );

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic zero_run;
   logic zr;

   // Digit 3 opens a new frame, so the run restarts there
   assign zr = (sel == 2'd3) | zero_run;
   assign lz = zr & (digit_res == 4'd0) & (sel != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_run <= 1'b1;
      end else begin
         zero_run <= zr & (digit_res == 4'd0);
      end
   end
`else
   assign lz = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         sel        <= 2'd3;
         state      <= ST_BLANK;
         an         <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= last ? '0 : cnt + 1'b1;
         frame_tick <= last && (sel == 2'd0);
         if (last) begin
            sel <= sel - 2'd1;
         end
         unique case (state)
            ST_BLANK: begin
               if (blank_end) begin
                  state <= ST_SHOW;
                  an    <= ~(4'b0001 << sel);
               end
            end
            ST_SHOW: begin
               if (last) begin
                  state <= ST_BLANK;
                  an    <= AN_OFF;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         seg <= (blank_mask[sel] | lz) ? SEG_OFF : glyph;
         dp  <= blank_mask[sel] | ~dp_mask[sel];
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver.
// Reference model derives expected outputs from the cycle index.
module tb_seg_scan_driver;

   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = 4 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digit_res;
   logic [3:0] dp_mask = 4'h0;
   logic [3:0] blank_mask = 4'h0;
   logic [1:0] sel;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   logic [3:0] digits [4];
   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int         k;
   int         n_chk = 0;
   int         n_fail = 0;
   int         ticks;
   logic [6:0] exp_seg;
   logic       exp_dp;

   always #5 clk = ~clk;

   // Selector model: digit value follows the DUT's select
   assign digit_res = digits[sel];

   seg_scan_driver #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK),
      .PWM_DUTY     (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digit_res  (digit_res),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
      .sel        (sel),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   function automatic logic [1:0] m_sel(input int kk);
      return 2'(3 - ((kk / CLK_DIV) % 4));
   endfunction

   function automatic logic [3:0] m_an(input int kk);
      logic [3:0] one;
      one = 4'b0001 << m_sel(kk);
      return ((kk % CLK_DIV) >= BLANK) ? ~one : 4'hF;
   endfunction

   function automatic logic m_tick(input int kk);
      return (kk > 0) && (kk % FRAME == 0);
   endfunction

   function automatic logic m_lz(input logic [1:0] ms);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (ms == 2'd0) return 1'b0;
      for (int j = int'(ms); j < 4; j++)
         if (digits[j] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return ms > 2'd3;
`endif
   endfunction

   task automatic step(input string tag);
      logic [1:0] ms;
      @(posedge clk);
      ms = m_sel(k);
      exp_seg = (blank_mask[ms] | m_lz(ms)) ? 7'h7F : glyph[digits[ms]];
      exp_dp  = blank_mask[ms] | ~dp_mask[ms];
      k++;
      @(negedge clk);
      n_chk++;
      if (sel !== m_sel(k)) begin
         n_fail++;
         $display("FAIL %s sel k=%0d got %0d exp %0d", tag, k, sel, m_sel(k));
      end
      n_chk++;
      if (an !== m_an(k)) begin
         n_fail++;
         $display("FAIL %s an k=%0d got %b exp %b", tag, k, an, m_an(k));
      end
      n_chk++;
      if (seg !== exp_seg) begin
         n_fail++;
         $display("FAIL %s seg k=%0d got %h exp %h", tag, k, seg, exp_seg);
      end
      n_chk++;
      if (dp !== exp_dp) begin
         n_fail++;
         $display("FAIL %s dp k=%0d got %b exp %b", tag, k, dp, exp_dp);
      end
      n_chk++;
      if (frame_tick !== m_tick(k)) begin
         n_fail++;
         $display("FAIL %s frame_tick k=%0d got %b exp %b",
                  tag, k, frame_tick, m_tick(k));
      end
      if (frame_tick === 1'b1) ticks++;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({sel, an, seg, dp, frame_tick} !== {2'd3, 4'hF, 7'h7F, 1'b1, 1'b0})
      begin
         n_fail++;
         $display("FAIL %s reset sel=%0d an=%b seg=%h dp=%b tick=%b exp 3 1111 7f 1 0",
                  tag, sel, an, seg, dp, frame_tick);
      end
      rst = 1'b0;
      k = 0;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) digits[i] = 4'(i);
      dp_mask = 4'hF;
      blank_mask = 4'h0;
      do_reset("reset");
      step("reset_first");
   endtask

   task automatic test_basic_scan();
      digits[3] = 4'd1;
      digits[2] = 4'd2;
      digits[1] = 4'd3;
      digits[0] = 4'd4;
      dp_mask = 4'h0;
      blank_mask = 4'h0;
      do_reset("scan");
      for (int i = 0; i < FRAME + CLK_DIV; i++) step("scan");
   endtask

   task automatic test_frame_tick();
      for (int i = 0; i < 4; i++) digits[i] = 4'($urandom_range(15));
      dp_mask = 4'($urandom_range(15));
      blank_mask = 4'h0;
      do_reset("tick");
      ticks = 0;
      for (int i = 0; i < 3 * FRAME + 2; i++) step("tick");
      n_chk++;
      if (ticks != 3) begin
         n_fail++;
         $display("FAIL tick_count got %0d exp 3", ticks);
      end
   endtask

   task automatic test_masks();
      for (int i = 0; i < 4; i++) digits[i] = 4'($urandom_range(1, 15));
      blank_mask = 4'b0100;
      dp_mask = 4'b0010;
      do_reset("mask");
      for (int i = 0; i < FRAME + 4; i++) step("mask");
   endtask

   task automatic test_reset_mid_show();
      for (int i = 0; i < 4; i++) digits[i] = 4'($urandom_range(1, 15));
      blank_mask = 4'h0;
      dp_mask = 4'hF;
      do_reset("midrst");
      while (!(m_sel(k) == 2'd1 && (k % CLK_DIV) == 4)) step("midrst_pre");
      rst = 1'b1;
      #1;
      n_chk++;
      if ({sel, an, seg, dp, frame_tick} !== {2'd3, 4'hF, 7'h7F, 1'b1, 1'b0})
      begin
         n_fail++;
         $display("FAIL midrst async sel=%0d an=%b seg=%h dp=%b tick=%b exp 3 1111 7f 1 0",
                  sel, an, seg, dp, frame_tick);
      end
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
      for (int i = 0; i < 2 * CLK_DIV; i++) step("midrst_post");
   endtask

   task automatic test_sweep();
      int v;
      for (int i = 1; i < 4; i++) digits[i] = 4'($urandom_range(1, 15));
      digits[0] = 4'd0;
      blank_mask = 4'h0;
      dp_mask = 4'($urandom_range(15));
      do_reset("sweep");
      v = 0;
      while (v < 16) begin
         if (m_sel(k) == 2'd0) begin
            digits[0] = 4'(v);
            v++;
         end
         step("sweep");
      end
      step("sweep_tail");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) digits[i] = 4'($urandom_range(15));
         dp_mask = 4'($urandom_range(15));
         blank_mask = 4'($urandom_range(15));
         do_reset("rand");
         for (int i = 0; i < FRAME + 3; i++) step("rand");
      end
   endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      digits[3] = 4'd0;
      digits[2] = 4'd0;
      digits[1] = 4'd5;
      digits[0] = 4'd0;
      dp_mask = 4'b1000;
      blank_mask = 4'h0;
      do_reset("lz005");
      for (int i = 0; i < FRAME + 2; i++) step("lz005");
      for (int i = 0; i < 4; i++) digits[i] = 4'd0;
      dp_mask = 4'h0;
      do_reset("lz000");
      for (int i = 0; i < FRAME + 2; i++) step("lz000");
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) digits[i] = 4'd0;
      k = 0;
      ticks = 0;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
      test_reset();
      test_basic_scan();
      test_frame_tick();
      test_masks();
      test_reset_mid_show();
      test_sweep();
      test_random();
`ifdef SEG_LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
